// File: rtl/mac_stream_pkg.sv
// Shared types and constants for the MAC result streaming path.
// Used by the output collector and its pair FIFO.
package mac_stream_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic LANE_0 = 1'b0;
    localparam logic LANE_1 = 1'b1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LANE0,
        S_LANE1,
        S_DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding result pairs.
// Full/empty come from an extra pointer wrap bit; no bypass path.
module pair_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = push && !full && !rst;
    assign do_rd = pop && !empty && !rst;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/collect_demux2_1.sv
// Collects MAC result pairs and serializes them lane 0 then lane 1.
// Counts emitted pairs and parks in DONE after TOTAL_PAIRS.
module collect_demux2_1
    import mac_stream_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = 4,
    parameter int TOTAL_PAIRS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_last,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(TOTAL_PAIRS);
    localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL_PAIRS - 1);
    localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        pair_cnt;
    logic [2*WIDTH-1:0]   head;
    logic                 full;
    logic                 empty;
    logic [AW:0]          level;
    logic                 push;
    logic                 pop;
    logic                 at_last;

    assign done     = (state == S_DONE);
    assign in_ready = en && !full && !done && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_LANE1) && out_ready;
    assign at_last  = (pair_cnt == LAST_CNT);

    pair_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_data1, in_data0}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Output-side FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    // Next state; a push into an idle collector starts lane 0 right away.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_EMPTY: begin
                if (push || !empty)
                    state_nx = S_LANE0;
            end
            S_LANE0: begin
                if (out_ready)
                    state_nx = S_LANE1;
            end
            S_LANE1: begin
                if (out_ready) begin
                    if (at_last)
                        state_nx = S_DONE;
                    else if (level > ONE_LVL || push)
                        state_nx = S_LANE0;
                    else
                        state_nx = S_EMPTY;
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
        endcase
    end

    // Pair counter advances on every accepted lane-1 beat.
    always_ff @(posedge clk) begin
        if (rst)
            pair_cnt <= '0;
        else if (pop)
            pair_cnt <= pair_cnt + 1'b1;
    end

    // Output muxing; data forced to zero when no beat is offered.
    always_comb begin
        out_valid = (state == S_LANE0) || (state == S_LANE1);
        out_sel   = (state == S_LANE1) ? LANE_1 : LANE_0;
        out_last  = (state == S_LANE1) && at_last;
        out_data  = '0;
        if (out_valid)
            out_data = out_sel ? head[2*WIDTH-1:WIDTH]
                               : head[WIDTH-1:0];
    end

endmodule

// File: tb/tb_collect_demux2_1.sv
// Directed bench for collect_demux2_1: vector table plus
// hand-written fill, enable, reset and terminal sequences.
module tb_collect_demux2_1;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data0;
    logic [15:0] in_data1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sel;
    logic        out_last;
    logic        done;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        en;
        logic        iv;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [15:0] od;
        logic        sel;
        logic        last;
        logic        dn;
    } vec_t;

    vec_t tbl [13];

    collect_demux2_1 #(
        .WIDTH       (16),
        .DEPTH       (4),
        .TOTAL_PAIRS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic e, input logic iv,
        input logic [15:0] d0, input logic [15:0] d1,
        input logic ordy, input logic ir, input logic ov,
        input logic [15:0] od, input logic sel,
        input logic last, input logic dn);
        vec_t v;
        v.rst = r;   v.en = e;     v.iv = iv;
        v.d0 = d0;   v.d1 = d1;    v.ordy = ordy;
        v.ir = ir;   v.ov = ov;    v.od = od;
        v.sel = sel; v.last = last; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs after negedge, check outputs 1ns later.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        en        = v.en;
        in_valid  = v.iv;
        in_data0  = v.d0;
        in_data1  = v.d1;
        out_ready = v.ordy;
        #1;
        chk({nm, ".in_ready"},  16'(in_ready),  16'(v.ir));
        chk({nm, ".out_valid"}, 16'(out_valid), 16'(v.ov));
        chk({nm, ".out_data"},  out_data,       v.od);
        chk({nm, ".out_sel"},   16'(out_sel),   16'(v.sel));
        chk({nm, ".out_last"},  16'(out_last),  16'(v.last));
        chk({nm, ".done"},      16'(done),      16'(v.dn));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_data0  = '0;
        in_data1  = '0;
        out_ready = 1'b0;
        @(posedge clk);

        // reset, single pair, then a lane-1 backpressure stall
        tbl[0]  = mk(1,1,0,16'h0,16'h0,1,     0,0,16'h0,0,0,0);
        tbl[1]  = mk(0,1,1,16'h0AAA,16'h0BBB,1, 1,0,16'h0,0,0,0);
        tbl[2]  = mk(0,1,0,16'h0,16'h0,1,     1,1,16'h0AAA,0,0,0);
        tbl[3]  = mk(0,1,0,16'h0,16'h0,1,     1,1,16'h0BBB,1,0,0);
        tbl[4]  = mk(0,1,1,16'h1111,16'h2222,1, 1,0,16'h0,0,0,0);
        tbl[5]  = mk(0,1,0,16'h0,16'h0,1,     1,1,16'h1111,0,0,0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0,1,0,16'h0,16'h0,0,  1,1,16'h2222,1,0,0);
        tbl[11] = mk(0,1,0,16'h0,16'h0,1,     1,1,16'h2222,1,0,0);
        tbl[12] = mk(0,1,0,16'h0,16'h0,1,     1,0,16'h0,0,0,0);

        for (int i = 0; i < 13; i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        // fill with out_ready low: in_ready drops after 4 pushes
        for (int k = 0; k < 5; k++)
            step($sformatf("fill%0d", k),
                 mk(0,1,1,16'(16'h3000 + k),16'(16'h4000 + k),0,
                    (k < 4),(k > 0),(k > 0) ? 16'h3000 : 16'h0,0,0,0));
        for (int j = 0; j < 8; j++)
            step($sformatf("drain%0d", j),
                 mk(0,1,0,16'h0,16'h0,1,
                    (j >= 2),1,
                    (j % 2 == 1) ? 16'(16'h4000 + j/2)
                                 : 16'(16'h3000 + j/2),
                    (j % 2 == 1),0,0));
        step("drain_end", mk(0,1,0,16'h0,16'h0,1, 1,0,16'h0,0,0,0));

        // en low blocks pushes; buffered data still drains
        step("en0_a", mk(0,0,1,16'h5555,16'h6666,1, 0,0,16'h0,0,0,0));
        step("en0_b", mk(0,0,1,16'h5555,16'h6666,1, 0,0,16'h0,0,0,0));
        step("en1_push", mk(0,1,1,16'h5555,16'h6666,1, 1,0,16'h0,0,0,0));
        step("en0_l0", mk(0,0,1,16'h7777,16'h7777,1, 0,1,16'h5555,0,0,0));
        step("en0_l1", mk(0,0,1,16'h7777,16'h7777,1, 0,1,16'h6666,1,0,0));
        step("en0_idle", mk(0,0,1,16'h7777,16'h7777,1, 0,0,16'h0,0,0,0));

        // reset on a lane-1 beat (which is the 8th pair) with 2 buffered
        step("rm_pa", mk(0,1,1,16'hA0A0,16'hA1A1,0, 1,0,16'h0,0,0,0));
        step("rm_pb", mk(0,1,1,16'hB0B0,16'hB1B1,0, 1,1,16'hA0A0,0,0,0));
        step("rm_l0", mk(0,1,0,16'h0,16'h0,1,       1,1,16'hA0A0,0,0,0));
        step("rm_rst", mk(1,1,0,16'h0,16'h0,1,      0,1,16'hA1A1,1,1,0));
        step("rm_after", mk(0,1,0,16'h0,16'h0,1,    1,0,16'h0,0,0,0));

        // full run of 8 pairs after the reset: out_last only on beat 16
        for (int p = 0; p < 8; p++) begin
            step($sformatf("term_push%0d", p),
                 mk(0,1,1,16'(16'hC000 + p),16'(16'hD000 + p),1,
                    1,0,16'h0,0,0,0));
            step($sformatf("term_l0_%0d", p),
                 mk(0,1,0,16'h0,16'h0,1,
                    1,1,16'(16'hC000 + p),0,0,0));
            step($sformatf("term_l1_%0d", p),
                 mk(0,1,0,16'h0,16'h0,1,
                    1,1,16'(16'hD000 + p),1,(p == 7),0));
        end
        for (int k = 0; k < 3; k++)
            step($sformatf("done%0d", k),
                 mk(0,1,1,16'hEEEE,16'hFFFF,1, 0,0,16'h0,0,0,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
